piarb_topic_value_mem: RTL and testbench

Topic-value memory controller for the PI arbiter. It owns a single-port topic-value RAM shared between the datapath lookup port and the PIO path. It services PIO reads and writes selected by the PIO decoder's `reg_ms_topic_value`, and returns `topic_value_mem_ack` / `topic_value_mem_rdata` to that decoder. Lookups have priority; a starvation counter bounds PIO latency.

---
 rtl/piarb_topic_value_mem_pkg.sv | 20 ++
 rtl/piarb_topic_value_mem_if.sv | 35 +++
 rtl/piarb_topic_value_mem_ram.sv | 26 ++
 rtl/piarb_topic_value_mem.sv | 134 +++++++++++++
 tb/tb_piarb_topic_value_mem.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piarb_topic_value_mem_pkg.sv
// Shared constants for the PI arbiter topic-value memory controller:
// bus width, default geometry, region constant and FSM state encodings.
package piarb_topic_value_mem_pkg;

  localparam int unsigned PIO_NBITS          = 32;
  localparam int unsigned TV_DEPTH_NBITS_DEF = 10;
  localparam int unsigned TV_STARVE_MAX_DEF  = 3;

  localparam logic [PIO_NBITS-1:0] PIARB_TOPIC_VALUE = 32'h0001_0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic is_pio_req(input logic rd, input logic wr, input logic ms);
    return (rd | wr) & ms;
  endfunction

endpackage

// File: rtl/piarb_topic_value_mem_if.sv
// PIO decoder and lookup-port signals of the topic-value memory controller.
// master = decoder/datapath side, slave = the controller.
interface piarb_topic_value_mem_if #(
  parameter int unsigned TV_DEPTH_NBITS = 10
);
  logic                                             clk_div;
  logic                                             reg_ms_topic_value;
  logic                                             reg_rd;
  logic                                             reg_wr;
  logic [piarb_topic_value_mem_pkg::PIO_NBITS-1:0]  reg_addr;
  logic [piarb_topic_value_mem_pkg::PIO_NBITS-1:0]  reg_din;
  logic                                             lu_req;
  logic [TV_DEPTH_NBITS-1:0]                        lu_addr;
  logic                                             lu_ready;
  logic                                             lu_rvalid;
  logic [piarb_topic_value_mem_pkg::PIO_NBITS-1:0]  lu_rdata;
  logic                                             topic_value_mem_ack;
  logic [piarb_topic_value_mem_pkg::PIO_NBITS-1:0]  topic_value_mem_rdata;
  logic                                             pio_overrun;

  modport master (
    output clk_div, reg_ms_topic_value, reg_rd, reg_wr, reg_addr, reg_din,
    output lu_req, lu_addr,
    input  lu_ready, lu_rvalid, lu_rdata,
    input  topic_value_mem_ack, topic_value_mem_rdata, pio_overrun
  );

  modport slave (
    input  clk_div, reg_ms_topic_value, reg_rd, reg_wr, reg_addr, reg_din,
    input  lu_req, lu_addr,
    output lu_ready, lu_rvalid, lu_rdata,
    output topic_value_mem_ack, topic_value_mem_rdata, pio_overrun
  );

endinterface

// File: rtl/piarb_topic_value_mem_ram.sv
// Single-port synchronous topic-value RAM: registered read, read-first
// on a same-address write, contents not reset.
module piarb_tv_ram #(
  parameter int unsigned ADDR_NBITS = 10,
  parameter int unsigned DATA_NBITS = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_NBITS-1:0] addr,
  input  logic [DATA_NBITS-1:0] wdata,
  output logic [DATA_NBITS-1:0] rdata
);

  logic [DATA_NBITS-1:0] mem [0:(1 << ADDR_NBITS)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/piarb_topic_value_mem.sv
// Topic-value memory controller: arbitrates the shared RAM between the
// lookup port (priority) and PIO accesses, with a starvation bound on PIO.
module piarb_topic_value_mem
  import piarb_topic_value_mem_pkg::*;
#(
  parameter int unsigned TV_DEPTH_NBITS = TV_DEPTH_NBITS_DEF,
  parameter int unsigned TV_STARVE_MAX  = TV_STARVE_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  piarb_topic_value_mem_if.slave   bus
);

  localparam int unsigned SW = (TV_STARVE_MAX < 1) ? 1 : $clog2(TV_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(TV_STARVE_MAX);

  logic [1:0]                state;
  logic                      op_wr;
  logic [TV_DEPTH_NBITS-1:0] op_idx;
  logic [PIO_NBITS-1:0]      op_din;
  logic [SW-1:0]             starve_cnt;

  logic                      lu_pend;
  logic                      lu_rvalid_q;
  logic [PIO_NBITS-1:0]      lu_rdata_q;
  logic [PIO_NBITS-1:0]      pio_rdata_q;
  logic                      overrun_q;

  logic                      pio_req;
  logic                      lu_ready;
  logic                      lu_take;
  logic                      pio_take;

  logic                      ram_en;
  logic                      ram_we;
  logic [TV_DEPTH_NBITS-1:0] ram_addr;
  logic [PIO_NBITS-1:0]      ram_wdata;
  logic [PIO_NBITS-1:0]      ram_rdata;

  logic                      addr_unused;

  // Byte-lane and above-depth address bits are don't-care: addresses alias.
  assign addr_unused = ^{bus.reg_addr[PIO_NBITS-1:TV_DEPTH_NBITS+2], bus.reg_addr[1:0]};

  always_comb begin
    pio_req   = is_pio_req(bus.reg_rd, bus.reg_wr, bus.reg_ms_topic_value);
    lu_ready  = !((state == ST_WAIT) && (starve_cnt == STARVE_LIM));
    lu_take   = bus.lu_req & lu_ready;
    pio_take  = (state == ST_WAIT) & ~lu_take;
    ram_en    = lu_take | pio_take;
    ram_we    = pio_take & op_wr;
    ram_addr  = pio_take ? op_idx : bus.lu_addr;
    ram_wdata = op_din;
  end

  piarb_tv_ram #(
    .ADDR_NBITS (TV_DEPTH_NBITS),
    .DATA_NBITS (PIO_NBITS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Lookup return pipe: RAM data arrives the cycle after accept, registered once more.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lu_pend     <= 1'b0;
      lu_rvalid_q <= 1'b0;
      lu_rdata_q  <= '0;
    end else begin
      lu_pend     <= lu_take;
      lu_rvalid_q <= lu_pend;
      if (lu_pend) begin
        lu_rdata_q <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      op_wr       <= 1'b0;
      op_idx      <= '0;
      op_din      <= '0;
      starve_cnt  <= '0;
      pio_rdata_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= pio_req && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (pio_req) begin
            op_wr      <= bus.reg_wr;
            op_idx     <= bus.reg_addr[TV_DEPTH_NBITS+1:2];
            op_din     <= bus.reg_din;
            starve_cnt <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lu_take) begin
            starve_cnt <= starve_cnt + 1'b1;
          end else begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!op_wr) begin
            pio_rdata_q <= ram_rdata;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.clk_div) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.lu_ready              = lu_ready;
  assign bus.lu_rvalid             = lu_rvalid_q;
  assign bus.lu_rdata              = lu_rdata_q;
  assign bus.topic_value_mem_ack   = (state == ST_DONE);
  assign bus.topic_value_mem_rdata = pio_rdata_q;
  assign bus.pio_overrun           = overrun_q;

endmodule

// File: tb/tb_piarb_topic_value_mem.sv
// Directed self-checking bench for piarb_topic_value_mem: one task per
// scenario, cycle-accurate expectations relative to the request cycle R.
module tb_piarb_topic_value_mem;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  piarb_topic_value_mem_if #(.TV_DEPTH_NBITS(10)) bus ();

  piarb_topic_value_mem #(
    .TV_DEPTH_NBITS (10),
    .TV_STARVE_MAX  (3)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clk_div            = 1'b1;
    bus.reg_ms_topic_value = 1'b1;
    bus.reg_rd             = 1'b0;
    bus.reg_wr             = 1'b0;
    bus.reg_addr           = '0;
    bus.reg_din            = '0;
    bus.lu_req             = 1'b0;
    bus.lu_addr            = '0;
  endtask

  // Issues one PIO access and returns once the FSM is back in IDLE.
  task automatic do_pio(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] din);
    bit seen;
    bus.reg_wr   = wr;
    bus.reg_rd   = rd;
    bus.reg_addr = addr;
    bus.reg_din  = din;
    step();
    bus.reg_wr = 1'b0;
    bus.reg_rd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.topic_value_mem_ack === 1'b1) seen = 1'b1;
      else step();
    end
    tests++;
    if (!seen) begin
      $display("FAIL pio_ack_timeout addr=%h got no ack, required ack within 20 cycles", addr);
      fails++;
    end
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (3) step();
    tests++;
    if (bus.lu_ready !== 1'b1) begin
      $display("FAIL reset_lu_ready got %b required 1", bus.lu_ready); fails++;
    end
    tests++;
    if (bus.lu_rvalid !== 1'b0) begin
      $display("FAIL reset_lu_rvalid got %b required 0", bus.lu_rvalid); fails++;
    end
    tests++;
    if (bus.topic_value_mem_ack !== 1'b0) begin
      $display("FAIL reset_ack got %b required 0", bus.topic_value_mem_ack); fails++;
    end
    tests++;
    if (bus.pio_overrun !== 1'b0) begin
      $display("FAIL reset_overrun got %b required 0", bus.pio_overrun); fails++;
    end
    tests++;
    if (bus.topic_value_mem_rdata !== 32'h0) begin
      $display("FAIL reset_rdata got %h required 0", bus.topic_value_mem_rdata); fails++;
    end
    tests++;
    if (bus.lu_rdata !== 32'h0) begin
      $display("FAIL reset_lu_rdata got %h required 0", bus.lu_rdata); fails++;
    end
    rstn = 1'b1;
    step();
    // Request without region select must be ignored.
    bus.reg_ms_topic_value = 1'b0;
    bus.reg_rd             = 1'b1;
    step();
    bus.reg_rd             = 1'b0;
    bus.reg_ms_topic_value = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.topic_value_mem_ack !== 1'b0 || bus.pio_overrun !== 1'b0) begin
        $display("FAIL unselected_req k=%0d ack=%b overrun=%b required 0/0", k,
                 bus.topic_value_mem_ack, bus.pio_overrun);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_pio_write_read();
    logic [3:0] exp_ack;
    exp_ack = 4'b1000;
    repeat (3) step();
    bus.reg_wr   = 1'b1;
    bus.reg_addr = 32'h0000_0014;
    bus.reg_din  = 32'hDEAD_BEEF;
    for (int k = 0; k <= 4; k++) begin
      if (k == 1) bus.reg_wr = 1'b0;
      if (k >= 1) begin
        tests++;
        if (bus.topic_value_mem_ack !== (k == 3 ? 1'b1 : 1'b0)) begin
          $display("FAIL write_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack,
                   (k == 3) ? 1'b1 : 1'b0);
          fails++;
        end
      end
      step();
    end
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_0014;
    for (int k = 0; k <= 3; k++) begin
      if (k == 1) bus.reg_rd = 1'b0;
      tests++;
      if (bus.topic_value_mem_ack !== exp_ack[k]) begin
        $display("FAIL read_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack, exp_ack[k]);
        fails++;
      end
      if (k == 3) begin
        tests++;
        if (bus.topic_value_mem_rdata !== 32'hDEAD_BEEF) begin
          $display("FAIL read_rdata got %h required deadbeef", bus.topic_value_mem_rdata);
          fails++;
        end
      end
      step();
    end
    step();
  endtask

  task automatic test_starve();
    logic [8:0] exp_ready;
    logic [8:0] exp_rvalid;
    logic [8:0] exp_ack;
    exp_ready  = 9'b1_1110_1111;
    exp_rvalid = 9'b1_1011_1100;
    exp_ack    = 9'b0_0100_0000;
    do_pio(1'b1, 1'b0, 32'h0000_001C, 32'h1234_5678);
    repeat (3) step();
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_0014;
    bus.lu_req   = 1'b1;
    bus.lu_addr  = 10'd7;
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) bus.reg_rd = 1'b0;
      tests++;
      if (bus.lu_ready !== exp_ready[k]) begin
        $display("FAIL starve_lu_ready R+%0d got %b required %b", k, bus.lu_ready, exp_ready[k]);
        fails++;
      end
      tests++;
      if (bus.lu_rvalid !== exp_rvalid[k]) begin
        $display("FAIL starve_lu_rvalid R+%0d got %b required %b", k, bus.lu_rvalid, exp_rvalid[k]);
        fails++;
      end
      tests++;
      if (bus.topic_value_mem_ack !== exp_ack[k]) begin
        $display("FAIL starve_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack, exp_ack[k]);
        fails++;
      end
      if (exp_rvalid[k]) begin
        tests++;
        if (bus.lu_rdata !== 32'h1234_5678) begin
          $display("FAIL starve_lu_rdata R+%0d got %h required 12345678", k, bus.lu_rdata);
          fails++;
        end
      end
      if (k == 6) begin
        tests++;
        if (bus.topic_value_mem_rdata !== 32'hDEAD_BEEF) begin
          $display("FAIL starve_rdata got %h required deadbeef", bus.topic_value_mem_rdata);
          fails++;
        end
      end
      step();
    end
    bus.lu_req = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_clk_div();
    logic [8:0] exp_ack;
    exp_ack = 9'b0_1111_1000;
    repeat (3) step();
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_0014;
    bus.clk_div  = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) bus.reg_rd = 1'b0;
      if (k == 7) bus.clk_div = 1'b1;
      tests++;
      if (bus.topic_value_mem_ack !== exp_ack[k]) begin
        $display("FAIL clkdiv_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack, exp_ack[k]);
        fails++;
      end
      step();
    end
    bus.clk_div = 1'b1;
  endtask

  task automatic test_overrun();
    int ovr;
    ovr = 0;
    repeat (3) step();
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_001C;
    for (int k = 0; k <= 7; k++) begin
      if (k == 1) bus.reg_rd = 1'b0;
      if (k == 2) bus.reg_rd = 1'b1;
      if (k == 3) bus.reg_rd = 1'b0;
      if (bus.pio_overrun === 1'b1) ovr++;
      tests++;
      if (bus.topic_value_mem_ack !== (k == 3 ? 1'b1 : 1'b0)) begin
        $display("FAIL overrun_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack,
                 (k == 3) ? 1'b1 : 1'b0);
        fails++;
      end
      if (k == 3) begin
        tests++;
        if (bus.topic_value_mem_rdata !== 32'h1234_5678) begin
          $display("FAIL overrun_rdata got %h required 12345678", bus.topic_value_mem_rdata);
          fails++;
        end
      end
      step();
    end
    tests++;
    if (ovr != 1) begin
      $display("FAIL overrun_pulses got %0d required 1", ovr);
      fails++;
    end
  endtask

  task automatic test_alias_both();
    repeat (3) step();
    bus.reg_rd   = 1'b1;
    bus.reg_wr   = 1'b1;
    bus.reg_addr = 32'd1029 << 2;
    bus.reg_din  = 32'hCAFE_F00D;
    for (int k = 0; k <= 5; k++) begin
      if (k == 1) begin
        bus.reg_rd = 1'b0;
        bus.reg_wr = 1'b0;
      end
      if (k == 2) begin
        bus.lu_req  = 1'b1;
        bus.lu_addr = 10'd5;
      end
      if (k == 3) bus.lu_req = 1'b0;
      if (k == 3) begin
        tests++;
        if (bus.topic_value_mem_ack !== 1'b1) begin
          $display("FAIL alias_ack got %b required 1", bus.topic_value_mem_ack); fails++;
        end
        tests++;
        if (bus.topic_value_mem_rdata !== 32'h1234_5678) begin
          $display("FAIL both_rdata_kept got %h required 12345678", bus.topic_value_mem_rdata);
          fails++;
        end
      end
      if (k == 4) begin
        tests++;
        if (bus.lu_rvalid !== 1'b1 || bus.lu_rdata !== 32'hCAFE_F00D) begin
          $display("FAIL lookup_after_write rvalid=%b data=%h required 1/cafef00d",
                   bus.lu_rvalid, bus.lu_rdata);
          fails++;
        end
      end
      step();
    end
    do_pio(1'b0, 1'b1, 32'hFFFF_F017, 32'h0);
    tests++;
    if (bus.topic_value_mem_rdata !== 32'hCAFE_F00D) begin
      $display("FAIL alias_read got %h required cafef00d", bus.topic_value_mem_rdata);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) step();
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_001C;
    step();
    bus.reg_rd = 1'b0;
    rstn       = 1'b0;
    #1;
    tests++;
    if (bus.topic_value_mem_ack !== 1'b0 || bus.lu_ready !== 1'b1) begin
      $display("FAIL midreset_outputs ack=%b lu_ready=%b required 0/1",
               bus.topic_value_mem_ack, bus.lu_ready);
      fails++;
    end
    tests++;
    if (bus.topic_value_mem_rdata !== 32'h0) begin
      $display("FAIL midreset_rdata got %h required 0", bus.topic_value_mem_rdata); fails++;
    end
    step();
    step();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.topic_value_mem_ack !== 1'b0 || bus.lu_ready !== 1'b1) begin
        $display("FAIL postreset k=%0d ack=%b lu_ready=%b required 0/1", k,
                 bus.topic_value_mem_ack, bus.lu_ready);
        fails++;
      end
      step();
    end
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 32'h0000_0014;
    for (int k = 0; k <= 4; k++) begin
      if (k == 1) bus.reg_rd = 1'b0;
      tests++;
      if (bus.topic_value_mem_ack !== (k == 3 ? 1'b1 : 1'b0)) begin
        $display("FAIL postreset_ack R+%0d got %b required %b", k, bus.topic_value_mem_ack,
                 (k == 3) ? 1'b1 : 1'b0);
        fails++;
      end
      if (k == 3) begin
        tests++;
        if (bus.topic_value_mem_rdata !== 32'hCAFE_F00D) begin
          $display("FAIL postreset_rdata got %h required cafef00d", bus.topic_value_mem_rdata);
          fails++;
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_pio_write_read();
    test_starve();
    test_clk_div();
    test_overrun();
    test_alias_both();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
